// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer, mid-bit sampling and
// break-safe frame-error recovery. All outputs are registered.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state,
  output logic       clk_enable
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   baud_reg, baud_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      data_out_reg, data_out_next;
  logic            data_valid_reg, data_valid_next;
  logic            frame_err_reg, frame_err_next;
  logic            busy_reg;
  logic            clk_enable_reg;
  logic            rx_meta_reg;
  logic            rx_s;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s        <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      baud_reg       <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      clk_enable_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      baud_reg       <= baud_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      frame_err_reg  <= frame_err_next;
      busy_reg       <= (state_next != IDLE);
      clk_enable_reg <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next      = state_reg;
    baud_next       = baud_reg;
    bit_next        = bit_reg;
    shift_next      = shift_reg;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          baud_next  = '0;
        end
      end
      START: begin
        if (baud_reg == HALF_LAST) begin
          baud_next = '0;
          if (!rx_s) begin
            state_next = DATA;
            bit_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      DATA: begin
        if (baud_reg == FULL_LAST) begin
          baud_next  = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == 3'd7) state_next = STOP;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      STOP: begin
        if (baud_reg == FULL_LAST) begin
          baud_next = '0;
          if (rx_s) begin
            data_out_next   = shift_reg;
            data_valid_next = 1'b1;
            state_next      = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = DONE;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      // Hold off until the line returns high so a break is one error, not many.
      DONE: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = busy_reg;
  assign state      = state_reg;
  assign clk_enable = clk_enable_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial transmitter drives rx,
// and expected bytes/pulse times are derived from frame start times.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int LAT = 154;  // raw start-edge to pulse, in clocks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] state;
  logic       clk_enable;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  logic [7:0] last_byte = 8'h00;

  int         obs_dv_cyc[$];
  logic [7:0] obs_dv_data[$];
  int         obs_fe_cyc[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .state      (state),
    .clk_enable (clk_enable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder; also flags simultaneous data_valid/frame_err.
  always @(negedge clk) begin
    if (data_valid) begin
      obs_dv_cyc.push_back(cyc);
      obs_dv_data.push_back(data_out);
    end
    if (frame_err) obs_fe_cyc.push_back(cyc);
    if (data_valid || frame_err) begin
      tests++;
      if (data_valid && frame_err) begin
        failed++;
        $display("FAIL pulse_exclusive: data_valid=%0b frame_err=%0b, required not both", data_valid, frame_err);
      end
    end
  end

  task automatic clear_obs();
    obs_dv_cyc.delete();
    obs_dv_data.delete();
    obs_fe_cyc.delete();
  endtask

  // Behavioural 8N1 transmitter; call at a negedge. n = edge that first sees start.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int n);
    rx = 1'b0;
    n  = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (state !== 3'd0)      begin failed++; $display("FAIL reset_state: got %0d, required 0", state); end
    tests++; if (busy !== 1'b0)       begin failed++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    tests++; if (data_out !== 8'h00)  begin failed++; $display("FAIL reset_data_out: got %02h, required 00", data_out); end
    tests++; if (data_valid !== 1'b0) begin failed++; $display("FAIL reset_data_valid: got %0b, required 0", data_valid); end
    tests++; if (frame_err !== 1'b0)  begin failed++; $display("FAIL reset_frame_err: got %0b, required 0", frame_err); end
    tests++; if (clk_enable !== 1'b1) begin failed++; $display("FAIL reset_clk_enable: got %0b, required 1", clk_enable); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (clk_enable !== 1'b0) begin failed++; $display("FAIL post_reset_clk_enable: got %0b, required 0", clk_enable); end
    last_byte = 8'h00;
  endtask

  task automatic test_basic();
    int n;
    clear_obs();
    @(negedge clk);
    send_frame(8'hA5, 1'b1, n);
    repeat (4) @(negedge clk);
    tests++; if (obs_dv_cyc.size() != 1) begin failed++; $display("FAIL basic_dv_count: got %0d, required 1", obs_dv_cyc.size()); end
    else begin
      tests++; if (obs_dv_cyc[0] != n + LAT) begin failed++; $display("FAIL basic_latency: got edge %0d, required %0d", obs_dv_cyc[0], n + LAT); end
      tests++; if (obs_dv_data[0] !== 8'hA5) begin failed++; $display("FAIL basic_data: got %02h, required a5", obs_dv_data[0]); end
    end
    tests++; if (obs_fe_cyc.size() != 0) begin failed++; $display("FAIL basic_fe_count: got %0d, required 0", obs_fe_cyc.size()); end
    tests++; if (data_out !== 8'hA5) begin failed++; $display("FAIL basic_data_hold: got %02h, required a5", data_out); end
    last_byte = 8'hA5;
  endtask

  task automatic test_glitch();
    clear_obs();
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    tests++; if (state !== 3'd1) begin failed++; $display("FAIL glitch_start: got state %0d, required 1", state); end
    repeat (20) @(negedge clk);
    tests++; if (state !== 3'd0) begin failed++; $display("FAIL glitch_idle: got state %0d, required 0", state); end
    tests++; if (obs_dv_cyc.size() + obs_fe_cyc.size() != 0) begin failed++; $display("FAIL glitch_pulses: got %0d, required 0", obs_dv_cyc.size() + obs_fe_cyc.size()); end
    tests++; if (data_out !== last_byte) begin failed++; $display("FAIL glitch_data_hold: got %02h, required %02h", data_out, last_byte); end
  endtask

  task automatic test_frame_err();
    int n;
    clear_obs();
    @(negedge clk);
    send_frame(8'h3C, 1'b0, n);
    repeat (24) @(negedge clk);  // line held low 40 clocks from stop-bit start
    tests++; if (state !== 3'd4) begin failed++; $display("FAIL fe_done_hold: got state %0d, required 4", state); end
    tests++; if (obs_fe_cyc.size() != 1) begin failed++; $display("FAIL fe_count: got %0d, required 1", obs_fe_cyc.size()); end
    else begin
      tests++; if (obs_fe_cyc[0] != n + LAT) begin failed++; $display("FAIL fe_latency: got edge %0d, required %0d", obs_fe_cyc[0], n + LAT); end
    end
    tests++; if (obs_dv_cyc.size() != 0) begin failed++; $display("FAIL fe_dv_count: got %0d, required 0", obs_dv_cyc.size()); end
    tests++; if (data_out !== last_byte) begin failed++; $display("FAIL fe_data_hold: got %02h, required %02h", data_out, last_byte); end
    rx = 1'b1;
    @(negedge clk);
    tests++; if (state !== 3'd4) begin failed++; $display("FAIL fe_done_sync: got state %0d, required 4", state); end
    repeat (3) @(negedge clk);
    tests++; if (state !== 3'd0) begin failed++; $display("FAIL fe_release: got state %0d, required 0", state); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;  // data bits of 0xFF
    repeat (40) @(negedge clk);
    tests++; if (state !== 3'd2) begin failed++; $display("FAIL rstmid_in_data: got state %0d, required 2", state); end
    rst = 1'b1;
    #1;
    tests++; if (state !== 3'd0 || busy !== 1'b0 || data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || clk_enable !== 1'b1) begin
      failed++;
      $display("FAIL rstmid_outputs: got st=%0d busy=%0b dout=%02h dv=%0b fe=%0b ce=%0b, required 0 0 00 0 0 1",
               state, busy, data_out, data_valid, frame_err, clk_enable);
    end
    @(negedge clk);
    rst = 1'b0;
    last_byte = 8'h00;
    repeat (150) @(negedge clk);
    clear_obs();
    send_frame(8'h12, 1'b1, n);
    repeat (4) @(negedge clk);
    tests++; if (obs_dv_cyc.size() != 1 || obs_fe_cyc.size() != 0) begin failed++; $display("FAIL rstmid_next_count: got dv=%0d fe=%0d, required 1 0", obs_dv_cyc.size(), obs_fe_cyc.size()); end
    else begin
      tests++; if (obs_dv_data[0] !== 8'h12 || obs_dv_cyc[0] != n + LAT) begin failed++; $display("FAIL rstmid_next_frame: got %02h@%0d, required 12@%0d", obs_dv_data[0], obs_dv_cyc[0], n + LAT); end
    end
    last_byte = 8'h12;
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    clear_obs();
    @(negedge clk);
    send_frame(8'h00, 1'b1, n1);
    send_frame(8'hFF, 1'b1, n2);
    repeat (4) @(negedge clk);
    tests++; if (obs_dv_cyc.size() != 2) begin failed++; $display("FAIL b2b_count: got %0d, required 2", obs_dv_cyc.size()); end
    else begin
      tests++; if (obs_dv_cyc[0] != n1 + LAT) begin failed++; $display("FAIL b2b_first_time: got %0d, required %0d", obs_dv_cyc[0], n1 + LAT); end
      tests++; if (obs_dv_cyc[1] - obs_dv_cyc[0] != 10 * CPB) begin failed++; $display("FAIL b2b_spacing: got %0d, required %0d", obs_dv_cyc[1] - obs_dv_cyc[0], 10 * CPB); end
      tests++; if (obs_dv_data[0] !== 8'h00 || obs_dv_data[1] !== 8'hFF) begin failed++; $display("FAIL b2b_data: got %02h %02h, required 00 ff", obs_dv_data[0], obs_dv_data[1]); end
    end
    last_byte = 8'hFF;
  endtask

  task automatic test_random();
    int         exp_cyc[$];
    logic [7:0] exp_data[$];
    int         n;
    logic [7:0] b;
    clear_obs();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      b = 8'($urandom);
      send_frame(b, 1'b1, n);
      exp_cyc.push_back(n + LAT);
      exp_data.push_back(b);
    end
    repeat (4) @(negedge clk);
    tests++; if (obs_dv_cyc.size() != exp_cyc.size()) begin failed++; $display("FAIL rand_count: got %0d, required %0d", obs_dv_cyc.size(), exp_cyc.size()); end
    else begin
      for (int k = 0; k < exp_cyc.size(); k++) begin
        tests++;
        if (obs_dv_data[k] !== exp_data[k] || obs_dv_cyc[k] != exp_cyc[k]) begin
          failed++;
          $display("FAIL rand_frame%0d: got %02h@%0d, required %02h@%0d", k, obs_dv_data[k], obs_dv_cyc[k], exp_data[k], exp_cyc[k]);
        end
      end
    end
    last_byte = exp_data[exp_data.size() - 1];
  endtask

  task automatic test_loopback();
    int n;
    clear_obs();
    @(negedge clk);
    send_frame(8'h5A, 1'b1, n);
    repeat (4) @(negedge clk);
    tests++; if (obs_dv_cyc.size() != 1 || data_out !== 8'h5A) begin failed++; $display("FAIL loop_data: got count %0d data %02h, required 1 5a", obs_dv_cyc.size(), data_out); end
    tests++; if (clk_enable !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL loop_idle: got ce=%0b busy=%0b, required 0 0", clk_enable, busy); end
    last_byte = 8'h5A;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_glitch();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Parameters
REQ-001 SHALL provide CLKS_PER_BIT, default 16, meaning clk cycles per bit time; legal values are even and at least 4.

Interface
REQ-002 SHALL have port clk, input, 1, single system clock; all logic is rising-edge; no gated clock.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port rx, input, 1, asynchronous serial line; idle high.
REQ-005 SHALL have port data_out, output, 8, last correctly framed byte received.
REQ-006 SHALL have port data_valid, output, 1, one-cycle pulse when data_out updates.
REQ-007 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have port state, output, 3, FSM state encoding.
REQ-010 SHALL have port clk_enable, output, 1, gating hint for downstream consumers.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); the FSM uses only the synchronized value rx_s.
REQ-012 SHALL encode states as IDLE=0, START=1, DATA=2, STOP=3, DONE=4; unused encodings go to IDLE on the next edge.
REQ-013 SHALL use a baud counter of width clog2(CLKS_PER_BIT) plus a 3-bit bit counter.
REQ-014 IDLE: when rx_s==0, SHALL go to START with baud counter=0; otherwise SHALL stay in IDLE.
REQ-015 START: SHALL increment the baud counter each cycle; at count CLKS_PER_BIT/2-1 with rx_s==0, SHALL go to DATA with baud counter=0 and bit counter=0.
REQ-016 START: at count CLKS_PER_BIT/2-1 with rx_s==1, SHALL treat the event as a false start and return to IDLE with no pulses.
REQ-017 DATA: at count CLKS_PER_BIT-1, SHALL right-shift rx_s into shift_reg[7] (LSB first), clear the baud counter and increment the bit counter.
REQ-018 DATA: after the 8th sample, SHALL go to STOP.
REQ-019 STOP: at count CLKS_PER_BIT-1 with rx_s==1, SHALL load data_out from shift_reg, pulse data_valid for 1 cycle and go to IDLE.
REQ-020 STOP: at count CLKS_PER_BIT-1 with rx_s==0, SHALL pulse frame_err for 1 cycle, leave data_out unchanged and go to DONE.
REQ-021 DONE: SHALL wait until rx_s==1, then go to IDLE, so that a break condition never retriggers START.
REQ-022 data_valid and frame_err SHALL never be high in the same cycle.
REQ-023 No consumer handshake: data_out holds until the next valid frame; a new frame overwrites it silently.
REQ-024 Latency: if raw rx is first sampled low at edge N, then with CLKS_PER_BIT=16 data_valid (or frame_err) SHALL be high after edge N+154, for one cycle only.
REQ-025 With CLKS_PER_BIT=16, the stop-bit sample SHALL correspond to raw-line time N+152, which is mid-bit.
REQ-026 A new start bit SHALL be accepted on the cycle after the return to IDLE, so back-to-back frames need zero idle bits.
REQ-027 clk_enable SHALL be 0 in IDLE and 1 in every other state; it SHALL be registered and update on the same edge as state.
REQ-028 busy SHALL be registered and update on the same edge as state.

Reset
REQ-029 While rst is high, outputs SHALL be: state=IDLE, busy=0, data_out=0x00, data_valid=0, frame_err=0, clk_enable=1; internally counters=0, shift_reg=0, synchronizer flops=1.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately with no pulse.
REQ-031 After reset release, the first edge with rx_s==1 in IDLE SHALL drive clk_enable to 0.

Verification
REQ-032 Send byte 0xA5 at 16 clk/bit with stop bit 1 -> data_out=0xA5, data_valid high for exactly one cycle after edge N+154, frame_err=0.
REQ-033 Drive a 4-cycle low glitch on idle rx -> START then IDLE, no data_valid or frame_err, data_out unchanged.
REQ-034 Send byte 0x3C with stop bit 0, hold rx low 40 cycles, then release high -> frame_err pulses once, state stays DONE until rx_s==1, data_out keeps its prior value.
REQ-035 Assert rst during the DATA phase of byte 0xFF -> all outputs at reset values; the next 0x12 frame is received correctly.
REQ-036 Send frames 0x00 then 0xFF back-to-back with no idle gap -> two data_valid pulses exactly 160 cycles apart, carrying 0x00 and then 0xFF.
REQ-037 Loopback from uart_tx (its tx output driving rx) sending 0x5A -> data_out=0x5A, data_valid once, clk_enable returns to 0 in IDLE.
